// File: rtl/shifter_iter.sv
// -----------------------------------------------------------------------------
// shifter_iter
//
// Iterative barrel shifter. A request is captured in IDLE, then the working
// register passes through C stages, one per clock. Stage k moves the data by
// 2^k positions when bit k of the captured shift count is set and holds it
// otherwise. The latency is therefore always C clocks, whatever the count.
//
// Parameters
//   N   data width in bits (must equal 2**C)
//   C   shift-count width
//   O   opcode width
//
// Ports
//   clk    single clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   start  request to begin an operation, only looked at in IDLE
//   In     operand, captured together with start
//   Cnt    shift amount 0..N-1, captured together with start
//   Op     00 rotate left, 01 shift left, 10 shift right arithmetic,
//          11 shift right logical; captured together with start
//   busy   high in every cycle the shifter is working
//   done   one-cycle pulse marking Out as freshly updated
//   Out    registered result, held between completions
// -----------------------------------------------------------------------------
module shifter_iter #(
    parameter int N = 16,
    parameter int C = 4,
    parameter int O = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] In,
    input  logic [C-1:0] Cnt,
    input  logic [O-1:0] Op,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Out
);

    // Stage distances go up to 2^(C-1), and the rotate needs N - distance,
    // so one extra bit covers both without overflow.
    localparam int            CW     = C + 1;
    localparam logic [CW-1:0] N_EXT  = CW'(N);
    localparam logic [C-1:0]  K_LAST = C'(C - 1);

    localparam logic [O-1:0] OP_ROL = O'(0);
    localparam logic [O-1:0] OP_SHL = O'(1);
    localparam logic [O-1:0] OP_SRA = O'(2);
    localparam logic [O-1:0] OP_SRL = O'(3);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   work_q,  work_d;
    logic [C-1:0]   cnt_q,   cnt_d;
    logic [O-1:0]   op_q,    op_d;
    logic [C-1:0]   k_q,     k_d;
    logic [N-1:0]   out_q,   out_d;
    logic           done_q,  done_d;

    logic [CW-1:0]  step;
    logic           stage_en;
    logic [N-1:0]   staged;

    // Select the count bit that governs the current stage. A compare loop is
    // used instead of cnt_q[k_q] so the index width stays exact.
    always_comb begin
        stage_en = 1'b0;
        for (int i = 0; i < C; i++) begin
            if (k_q == C'(i)) begin
                stage_en = cnt_q[i];
            end
        end
    end

    // One stage of the shifter: move the working value by 2^k when enabled.
    // Rotate brings the bits pushed out of the MSB end back in at the LSB
    // end; arithmetic right replicates the current MSB; the rest fill with 0.
    always_comb begin
        step   = CW'(1) << k_q;
        staged = work_q;
        if (stage_en) begin
            case (op_q)
                OP_ROL:  staged = (work_q << step) | (work_q >> (N_EXT - step));
                OP_SHL:  staged = work_q << step;
                OP_SRA:  staged = $unsigned($signed(work_q) >>> step);
                OP_SRL:  staged = work_q >> step;
                default: staged = work_q;
            endcase
        end
    end

    // Next-state and datapath control. Everything holds by default and done
    // drops unless this is the edge that finishes the last stage.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        k_d     = k_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = In;
                    cnt_d   = Cnt;
                    op_d    = Op;
                    k_d     = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                work_d = staged;
                k_d    = k_q + C'(1);
                if (k_q == K_LAST) begin
                    out_d   = staged;
                    done_d  = 1'b1;
                    k_d     = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset wins over everything, including a
    // simultaneous start and an operation in flight, and clears the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            k_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            k_q     <= k_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // busy follows the state directly; done is only ever high in IDLE, so
    // the two never overlap.
    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign Out  = out_q;

endmodule

// File: tb/tb_shifter_iter.sv
// -----------------------------------------------------------------------------
// tb_shifter_iter
//
// Bench for shifter_iter. Two instances are built: the default 16-bit one and
// a 32-bit one (C=5). Expected results are pushed onto a per-instance queue
// when a request is driven and popped by a monitor when done pulses.
// -----------------------------------------------------------------------------
module tb_shifter_iter;

    logic        clk = 1'b0;
    logic        rst;

    logic        start16;
    logic [15:0] in16;
    logic [3:0]  cnt16;
    logic [1:0]  op16;
    logic        busy16;
    logic        done16;
    logic [15:0] out16;

    logic        start32;
    logic [31:0] in32;
    logic [4:0]  cnt32;
    logic [1:0]  op32;
    logic        busy32;
    logic        done32;
    logic [31:0] out32;

    int          tests    = 0;
    int          failures = 0;

    logic [31:0] exp16_q[$];
    logic [31:0] exp32_q[$];
    logic [31:0] e16;
    logic [31:0] e32;

    typedef struct {
        string       name;
        logic [15:0] in_val;
        logic [3:0]  cnt;
        logic [1:0]  op;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    // 10-unit clock period shared by both instances.
    always #5 clk = ~clk;

    shifter_iter #(.N(16), .C(4), .O(2)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .In    (in16),
        .Cnt   (cnt16),
        .Op    (op16),
        .busy  (busy16),
        .done  (done16),
        .Out   (out16)
    );

    shifter_iter #(.N(32), .C(5), .O(2)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .start (start32),
        .In    (in32),
        .Cnt   (cnt32),
        .Op    (op32),
        .busy  (busy32),
        .done  (done32),
        .Out   (out32)
    );

    // Direct (non-iterative) reference: the whole shift in one expression,
    // masked to the instance width n.
    function automatic logic [31:0] ref_model(input int n, input logic [31:0] x,
                                              input int c, input int op);
        logic [31:0] mask;
        logic [31:0] xs;
        logic [31:0] r;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        xs   = x & mask;
        case (op)
            0: r = (c == 0) ? xs : ((xs << c) | (xs >> (n - c)));
            1: r = xs << c;
            2: begin
                if (xs[n-1]) xs = xs | ~mask;
                r = $unsigned($signed(xs) >>> c);
            end
            default: r = xs >> c;
        endcase
        return r & mask;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request for a full clock starting now; the next rising edge
    // samples it. When accept is set the expected result joins the queue.
    task automatic applyStimulus(input bit wide, input logic [31:0] a,
                                 input logic [4:0] c, input logic [1:0] o,
                                 input logic [31:0] e, input bit accept);
        if (wide) begin
            in32    = a;
            cnt32   = c;
            op32    = o;
            start32 = 1'b1;
            if (accept) exp32_q.push_back(e);
        end else begin
            in16    = a[15:0];
            cnt16   = c[3:0];
            op16    = o;
            start16 = 1'b1;
            if (accept) exp16_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start16 = 1'b0;
        start32 = 1'b0;
    endtask

    // Wait until every queued result for one instance has been seen, with a
    // bounded number of cycles.
    task automatic waitIdle(input bit wide);
        int n;
        int pending;
        n       = 0;
        pending = wide ? exp32_q.size() : exp16_q.size();
        while (pending != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            pending = wide ? exp32_q.size() : exp16_q.size();
        end
        if (pending != 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL wait_idle_timeout: %0d results still pending", pending);
            exp16_q.delete();
            exp32_q.delete();
        end
    endtask

    // Count edges from the start edge until done rises, and how many of those
    // cycles had busy high. Called right after applyStimulus returns.
    task automatic measureLatency(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (edges < 12) begin
            if (busy16) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
            if (done16) break;
        end
    endtask

    // Monitor for the 16-bit instance: on every done pulse compare Out with
    // the oldest expected value and make sure busy is low at the same time.
    always @(negedge clk) begin
        if (done16) begin
            checkOutput("busy16_with_done", {31'd0, busy16}, 32'd0);
            if (exp16_q.size() == 0) begin
                checkOutput("unexpected_done16", {31'd0, done16}, 32'd0);
            end else begin
                e16 = exp16_q.pop_front();
                checkOutput("out16", {16'd0, out16}, e16);
            end
        end
    end

    // Same monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (done32) begin
            checkOutput("busy32_with_done", {31'd0, busy32}, 32'd0);
            if (exp32_q.size() == 0) begin
                checkOutput("unexpected_done32", {31'd0, done32}, 32'd0);
            end else begin
                e32 = exp32_q.pop_front();
                checkOutput("out32", out32, e32);
            end
        end
    end

    // Hard stop in case something wedges the main sequence.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int          lat;
        int          bcyc;
        int          dcount;
        int          n;
        logic [31:0] a;
        logic [4:0]  c;
        logic [1:0]  o;

        rst     = 1'b1;
        start16 = 1'b0;
        in16    = '0;
        cnt16   = '0;
        op16    = '0;
        start32 = 1'b0;
        in32    = '0;
        cnt32   = '0;
        op32    = '0;

        vecs[0] = '{"shl4",  16'hABCD, 4'd4,  2'b01, 16'hBCD0};
        vecs[1] = '{"srl4",  16'hABCD, 4'd4,  2'b11, 16'h0ABC};
        vecs[2] = '{"sra4",  16'hABCD, 4'd4,  2'b10, 16'hFABC};
        vecs[3] = '{"rol4",  16'hABCD, 4'd4,  2'b00, 16'hBCDA};
        vecs[4] = '{"sra15", 16'h8000, 4'd15, 2'b10, 16'hFFFF};
        vecs[5] = '{"shl0",  16'h1234, 4'd0,  2'b01, 16'h1234};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy16", {31'd0, busy16}, 32'd0);
        checkOutput("reset_done16", {31'd0, done16}, 32'd0);
        checkOutput("reset_out16",  {16'd0, out16},  32'd0);
        checkOutput("reset_busy32", {31'd0, busy32}, 32'd0);
        checkOutput("reset_out32",  out32,           32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Rotate by one with the latency and busy window measured.
        applyStimulus(1'b0, 32'h8001, 5'd1, 2'b00, 32'h0003, 1'b1);
        measureLatency(lat, bcyc);
        checkOutput("rol1_latency", lat, 32'd4);
        checkOutput("rol1_busy_cycles", bcyc, 32'd4);
        @(posedge clk);
        #1;
        checkOutput("done_pulse_width", {31'd0, done16}, 32'd0);
        checkOutput("out_hold", {16'd0, out16}, 32'h0003);
        waitIdle(1'b0);

        // Vector table: every opcode at count 4, sign fill, zero count.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, {16'd0, vecs[i].in_val}, {1'b0, vecs[i].cnt},
                          vecs[i].op, {16'd0, vecs[i].exp_out}, 1'b1);
            waitIdle(1'b0);
        end

        // A zero count still takes the full latency.
        applyStimulus(1'b0, 32'h1234, 5'd0, 2'b01, 32'h1234, 1'b1);
        measureLatency(lat, bcyc);
        checkOutput("cnt0_latency", lat, 32'd4);
        waitIdle(1'b0);

        // A start while busy is ignored, operand changes during the operation
        // do not leak in, and a start in the done cycle is taken.
        applyStimulus(1'b0, 32'hABCD, 5'd4, 2'b01, 32'hBCD0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'hFFFF, 5'd1, 2'b00, 32'h0, 1'b0);
        in16  = 16'h5555;
        cnt16 = 4'd7;
        op16  = 2'b11;
        n = 0;
        while (!done16 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("first_done_seen", {31'd0, done16}, 32'd1);
        applyStimulus(1'b0, 32'h00F0, 5'd4, 2'b11, 32'h000F, 1'b1);
        measureLatency(lat, bcyc);
        checkOutput("b2b_latency", lat, 32'd4);
        waitIdle(1'b0);
        repeat (6) @(posedge clk);
        #1;

        // Reset in the second SHIFT cycle aborts with no done pulse.
        applyStimulus(1'b0, 32'hABCD, 5'd4, 2'b00, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", {31'd0, busy16}, 32'd0);
        checkOutput("abort_done", {31'd0, done16}, 32'd0);
        checkOutput("abort_out",  {16'd0, out16},  32'd0);
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (done16) dcount++;
        end
        checkOutput("abort_no_done", dcount, 32'd0);

        // Reset and start on the same edge: nothing is accepted.
        @(posedge clk);
        #1;
        rst     = 1'b1;
        start16 = 1'b1;
        in16    = 16'h1234;
        cnt16   = 4'd3;
        op16    = 2'b01;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        start16 = 1'b0;
        checkOutput("rst_start_busy", {31'd0, busy16}, 32'd0);
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (done16) dcount++;
        end
        checkOutput("rst_start_no_done", dcount, 32'd0);
        @(posedge clk);
        #1;

        // Randomised operations on the 16-bit instance.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            c = 5'($urandom_range(0, 15));
            o = 2'($urandom_range(0, 3));
            applyStimulus(1'b0, a, c, o, ref_model(16, a, int'(c), int'(o)), 1'b1);
            waitIdle(1'b0);
        end

        // 32-bit instance: a couple of hand-derived corners, then random.
        applyStimulus(1'b1, 32'h8000_0001, 5'd1, 2'b00, 32'h0000_0003, 1'b1);
        waitIdle(1'b1);
        applyStimulus(1'b1, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b1);
        waitIdle(1'b1);
        applyStimulus(1'b1, 32'h1234_5678, 5'd16, 2'b00, 32'h5678_1234, 1'b1);
        waitIdle(1'b1);
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            c = 5'($urandom_range(0, 31));
            o = 2'($urandom_range(0, 3));
            applyStimulus(1'b1, a, c, o, ref_model(32, a, int'(c), int'(o)), 1'b1);
            waitIdle(1'b1);
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
